iosys_ram_arbiter: RTL



---
 rtl/iosys_ram_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/iosys_ram_arbiter.sv
// Shares the 16-bit SDRAM port between a one-entry flash-loader write buffer and the
// PicoRV32 native bus. Each 32-bit CPU access is split into two sequenced halfword operations.
module iosys_ram_arbiter #(
    parameter logic [31:0] RAM_LIMIT = 32'h0080_0000
) (
    input  logic        wclk,
    input  logic        resetn,
    input  logic        boot_wr,
    input  logic [22:0] boot_addr,
    input  logic [15:0] boot_din,
    output logic        boot_ack,
    output logic        boot_full,
    output logic        boot_ovf,
    input  logic        cpu_valid,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic [22:0] ram_addr,
    output logic [15:0] ram_din,
    output logic [1:0]  ram_ds,
    output logic        ram_rd,
    output logic        ram_wr,
    input  logic [15:0] ram_dout,
    input  logic        ram_busy
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StIssue = 3'd1;
    localparam logic [2:0] StGuard = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StDone  = 3'd4;

    localparam logic OwnBoot = 1'b0;
    localparam logic OwnCpu  = 1'b1;

    logic [2:0]  state_q, state_d;
    logic        half_q, half_d;
    logic        owner_q, owner_d;

    logic        buf_full_q, buf_full_d;
    logic [21:0] buf_addr_q, buf_addr_d;
    logic [15:0] buf_data_q, buf_data_d;
    logic        ovf_q, ovf_d;

    logic [20:0] c_addr_q, c_addr_d;
    logic [31:0] c_wdata_q, c_wdata_d;
    logic [3:0]  c_wstrb_q, c_wstrb_d;

    logic [22:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic [1:0]  ram_ds_q, ram_ds_d;
    logic        ram_rd_q, ram_rd_d;
    logic        ram_wr_q, ram_wr_d;
    logic        boot_ack_q, boot_ack_d;
    logic        cpu_ready_q, cpu_ready_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;

    logic        boot_issue;
    logic        cpu_hit;
    logic        c_is_read;
    logic        c_hi_pending;
    logic        unused_addr_bits;

    // Halfword and word alignment bits are implied by the SDRAM addressing.
    assign unused_addr_bits = ^{boot_addr[0], cpu_addr[1:0]};

    assign boot_issue   = (state_q == StIssue) && (owner_q == OwnBoot) && !ram_busy;
    assign cpu_hit      = cpu_valid && (cpu_addr < RAM_LIMIT) && !cpu_ready_q;
    assign c_is_read    = (c_wstrb_q == 4'b0000);
    assign c_hi_pending = c_is_read || (c_wstrb_q[3:2] != 2'b00);

    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        owner_d     = owner_q;
        buf_full_d  = buf_full_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        ovf_d       = ovf_q;
        c_addr_d    = c_addr_q;
        c_wdata_d   = c_wdata_q;
        c_wstrb_d   = c_wstrb_q;
        ram_addr_d  = ram_addr_q;
        ram_din_d   = ram_din_q;
        ram_ds_d    = ram_ds_q;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        boot_ack_d  = 1'b0;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;

        // The buffer may be refilled on the very edge its current entry is issued.
        if (boot_wr) begin
            if (!buf_full_q || boot_issue) begin
                buf_addr_d = boot_addr[22:1];
                buf_data_d = boot_din;
                buf_full_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (boot_issue) begin
            buf_full_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (buf_full_q) begin
                    owner_d = OwnBoot;
                    state_d = StIssue;
                end else if (cpu_hit) begin
                    owner_d   = OwnCpu;
                    c_addr_d  = cpu_addr[22:2];
                    c_wdata_d = cpu_wdata;
                    c_wstrb_d = cpu_wstrb;
                    // A write with no low-half strobes skips straight to the high half.
                    half_d    = (cpu_wstrb != 4'b0000) && (cpu_wstrb[1:0] == 2'b00);
                    state_d   = StIssue;
                end
            end

            StIssue: begin
                if (!ram_busy) begin
                    if (owner_q == OwnBoot) begin
                        ram_addr_d = {buf_addr_q, 1'b0};
                        ram_din_d  = buf_data_q;
                        ram_ds_d   = 2'b11;
                        ram_wr_d   = 1'b1;
                        boot_ack_d = 1'b1;
                    end else begin
                        ram_addr_d = {c_addr_q, half_q, 1'b0};
                        ram_din_d  = half_q ? c_wdata_q[31:16] : c_wdata_q[15:0];
                        if (c_is_read) begin
                            ram_ds_d = 2'b11;
                        end else begin
                            ram_ds_d = half_q ? c_wstrb_q[3:2] : c_wstrb_q[1:0];
                        end
                        ram_rd_d = c_is_read;
                        ram_wr_d = !c_is_read;
                    end
                    state_d = StGuard;
                end
            end

            // The controller raises busy only the cycle after the strobe.
            StGuard: state_d = StWait;

            StWait: begin
                if (!ram_busy) begin
                    if (owner_q == OwnBoot) begin
                        state_d = StIdle;
                    end else begin
                        if (c_is_read) begin
                            if (half_q) begin
                                cpu_rdata_d[31:16] = ram_dout;
                            end else begin
                                cpu_rdata_d[15:0] = ram_dout;
                            end
                        end
                        if (!half_q && c_hi_pending) begin
                            half_d  = 1'b1;
                            state_d = StIssue;
                        end else begin
                            cpu_ready_d = 1'b1;
                            state_d     = StDone;
                        end
                    end
                end
            end

            StDone: state_d = StIdle;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            half_q      <= 1'b0;
            owner_q     <= OwnBoot;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            ovf_q       <= 1'b0;
            c_addr_q    <= '0;
            c_wdata_q   <= '0;
            c_wstrb_q   <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            ram_ds_q    <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            boot_ack_q  <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            half_q      <= half_d;
            owner_q     <= owner_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ovf_q       <= ovf_d;
            c_addr_q    <= c_addr_d;
            c_wdata_q   <= c_wdata_d;
            c_wstrb_q   <= c_wstrb_d;
            ram_addr_q  <= ram_addr_d;
            ram_din_q   <= ram_din_d;
            ram_ds_q    <= ram_ds_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            boot_ack_q  <= boot_ack_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign boot_ack  = boot_ack_q;
    assign boot_full = buf_full_q;
    assign boot_ovf  = ovf_q;
    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign ram_ds    = ram_ds_q;
    assign ram_rd    = ram_rd_q;
    assign ram_wr    = ram_wr_q;

endmodule
